// File: rtl/pool_stream_unit.sv
// Streaming non-overlapping KxK (K=2/3) pooling engine; max always, average under AVG_POOL_EN.
// Keeps one running accumulator per output column instead of buffering whole input rows.
module pool_stream_unit #(
    parameter int DATA_W  = 16,
    parameter int MAX_ROW = 256,
    parameter int ROW_W   = $clog2(MAX_ROW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  row_length,
    input  logic [ROW_W-1:0]  col_count,
    input  logic              pool_win,
    input  logic              pool_type,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int NCOL = MAX_ROW / 2;
    localparam int OC_W = $clog2(NCOL);
    localparam int GW   = ROW_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;
    logic [ROW_W-1:0] row_len_q, row_len_d;
    logic [ROW_W-1:0] col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0] c_q, c_d;
    logic [ROW_W-1:0] r_q, r_d;
    logic [1:0] kc_q, kc_d;
    logic [1:0] kr_q, kr_d;
    logic [OC_W-1:0] oc_q, oc_d;
    logic k3_q, k3_d;
    logic avg_q, avg_d;
    logic out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic done_q, done_d;

    logic signed [DATA_W-1:0] acc_q [NCOL];
    logic signed [DATA_W-1:0] acc_wdata;
    logic acc_we;

    logic fire, in_win, first_px, last_px;
    logic [1:0] kmax;
    logic [GW-1:0] kw, cs, rs;
    logic signed [DATA_W-1:0] pix, cur, max_new, result;

`ifdef AVG_POOL_EN
    localparam int SUM_W = DATA_W + 4;
    logic signed [SUM_W-1:0] sum_q [NCOL];
    logic signed [SUM_W-1:0] sum_new;
    logic signed [SUM_W+17:0] prod;
    logic signed [DATA_W-1:0] avg_res;
    logic unused_prod;
`else
    logic unused_cfg;
`endif

    always_comb begin
        kmax     = k3_q ? 2'd2 : 2'd1;
        kw       = k3_q ? GW'(3) : GW'(2);
        cs       = {1'b0, c_q} - GW'(kc_q);
        rs       = {1'b0, r_q} - GW'(kr_q);
        // window is kept only if it fits completely inside the frame
        in_win   = (cs + kw <= {1'b0, row_len_q}) &&
                   (rs + kw <= {1'b0, col_cnt_q});
        first_px = (kc_q == 2'd0) && (kr_q == 2'd0);
        last_px  = (kc_q == kmax) && (kr_q == kmax);
        in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
        fire     = in_valid && in_ready;
        pix      = $signed(in_data);
        cur      = acc_q[oc_q];
        max_new  = (first_px || pix > cur) ? pix : cur;
        acc_we   = fire && in_win;
        acc_wdata = max_new;
    end

`ifdef AVG_POOL_EN
    always_comb begin
        sum_new = first_px ? {{4{pix[DATA_W-1]}}, pix}
                           : sum_q[oc_q] + {{4{pix[DATA_W-1]}}, pix};
        prod    = sum_new * 18'sd7282;
        avg_res = k3_q ? prod[16 +: DATA_W] : sum_new[2 +: DATA_W];
        result  = avg_q ? avg_res : max_new;
    end

    assign unused_prod = ^{prod[15:0], prod[SUM_W+17:16+DATA_W]};
`else
    assign result     = max_new;
    assign unused_cfg = avg_q;
`endif

    always_comb begin
        state_d     = state_q;
        row_len_d   = row_len_q;
        col_cnt_d   = col_cnt_q;
        k3_d        = k3_q;
        avg_d       = avg_q;
        c_d         = c_q;
        r_d         = r_q;
        kc_d        = kc_q;
        kr_d        = kr_q;
        oc_d        = oc_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_len_d = row_length;
                    col_cnt_d = col_count;
                    k3_d      = pool_win;
`ifdef AVG_POOL_EN
                    avg_d     = pool_type;
`else
                    avg_d     = 1'b0;
`endif
                    c_d  = '0;
                    r_d  = '0;
                    kc_d = '0;
                    kr_d = '0;
                    oc_d = '0;
                    if (row_length == '0 || col_count == '0)
                        state_d = S_FLUSH;
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (in_win && last_px) begin
                        out_valid_d = 1'b1;
                        out_data_d  = result;
                    end
                    if (c_q == row_len_q - ROW_W'(1)) begin
                        c_d  = '0;
                        kc_d = '0;
                        oc_d = '0;
                        kr_d = (kr_q == kmax) ? 2'd0 : kr_q + 2'd1;
                        if (r_q == col_cnt_q - ROW_W'(1))
                            state_d = S_FLUSH;
                        else
                            r_d = r_q + ROW_W'(1);
                    end else begin
                        c_d = c_q + ROW_W'(1);
                        if (kc_q == kmax) begin
                            kc_d = '0;
                            oc_d = oc_q + OC_W'(1);
                        end else begin
                            kc_d = kc_q + 2'd1;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            row_len_q   <= '0;
            col_cnt_q   <= '0;
            k3_q        <= 1'b0;
            avg_q       <= 1'b0;
            c_q         <= '0;
            r_q         <= '0;
            kc_q        <= '0;
            kr_q        <= '0;
            oc_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_len_q   <= row_len_d;
            col_cnt_q   <= col_cnt_d;
            k3_q        <= k3_d;
            avg_q       <= avg_d;
            c_q         <= c_d;
            r_q         <= r_d;
            kc_q        <= kc_d;
            kr_q        <= kr_d;
            oc_q        <= oc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCOL; i++) acc_q[i] <= '0;
        end else if (acc_we) begin
            acc_q[oc_q] <= acc_wdata;
        end
    end

`ifdef AVG_POOL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCOL; i++) sum_q[i] <= '0;
        end else if (acc_we) begin
            sum_q[oc_q] <= sum_new;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_pool_stream_unit.sv
// Scoreboard bench for pool_stream_unit: directed frames with hand-computed pooled results.
module tb_pool_stream_unit;
    localparam int DW = 16;
    localparam int RW = 9;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [RW-1:0] row_length, col_count;
    logic pool_win, pool_type;
    logic in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic busy, done;

    pool_stream_unit dut (
        .clk(clk), .rst(rst), .start(start),
        .row_length(row_length), .col_count(col_count),
        .pool_win(pool_win), .pool_type(pool_type),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    int out_cnt = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    int stalled = 0;
    bit stall = 1'b0;
    int stall_cnt = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // monitor: compares every accepted output against the scoreboard
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_valid && out_ready) begin
                out_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected got %0d expected none",
                             $signed(out_data));
                end else begin
                    chk("out_data", int'($signed(out_data)), exp_q.pop_front());
                end
            end else if (out_valid && !out_ready && exp_q.size() > 0) begin
                chk("held_data", int'($signed(out_data)), exp_q[0]);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (stall && out_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
        end else begin
            out_ready = 1'b1;
            if (out_valid) stall_cnt = 0;
        end
    end

    task automatic start_frame(input int rl, input int cc, input bit w, input bit t);
        row_length = RW'(rl);
        col_count  = RW'(cc);
        pool_win   = w;
        pool_type  = t;
        start      = 1'b1;
        @(posedge clk) #1;
        start      = 1'b0;
    endtask

    task automatic feed(input int pix);
        int n = 0;
        in_valid = 1'b1;
        in_data  = DW'(pix);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            stalled++;
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout got stalled expected accept");
        end
        @(posedge clk) #1;
    endtask

    task automatic wait_done(input string nm);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_done"}, done_cnt - d0, 1);
        #1;
        chk({nm, "_sb_empty"}, exp_q.size(), 0);
        @(negedge clk);
        chk({nm, "_busy_idle"}, int'(busy), 0);
        @(posedge clk) #1;
    endtask

    task automatic ramp(input int rl, input int cc, input bit w, input bit t);
        start_frame(rl, cc, w, t);
        @(negedge clk);
        chk("busy_run", int'(busy), 1);
        @(posedge clk) #1;
        for (int i = 0; i < rl * cc; i++) feed(i);
        in_valid = 1'b0;
    endtask

    initial begin
        int o0;
        rst = 1'b0;
        start = 1'b0;
        row_length = '0;
        col_count = '0;
        pool_win = 1'b0;
        pool_type = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b1;
        @(posedge clk) #1;

        // 4x4 ramp, 2x2 max
        o0 = out_cnt;
        exp_q.push_back(5); exp_q.push_back(7);
        exp_q.push_back(13); exp_q.push_back(15);
        ramp(4, 4, 1'b0, 1'b0);
        wait_done("t1");
        chk("t1_count", out_cnt - o0, 4);
        chk("t1_done_latency", done_cyc - last_hs_cyc, 1);

        // same frame with downstream back-pressure
        stall = 1'b1;
        stalled = 0;
        o0 = out_cnt;
        exp_q.push_back(5); exp_q.push_back(7);
        exp_q.push_back(13); exp_q.push_back(15);
        ramp(4, 4, 1'b0, 1'b0);
        wait_done("t2");
        stall = 1'b0;
        chk("t2_count", out_cnt - o0, 4);
        chk("t2_in_ready_drop", int'(stalled > 0), 1);

        // 5x5 ramp: last row/column dropped
        o0 = out_cnt;
        exp_q.push_back(6); exp_q.push_back(8);
        exp_q.push_back(16); exp_q.push_back(18);
        ramp(5, 5, 1'b0, 1'b0);
        wait_done("t3");
        chk("t3_count", out_cnt - o0, 4);

        // 6x6 of -7 with -2 at centre of first 3x3 window
        o0 = out_cnt;
        exp_q.push_back(-2); exp_q.push_back(-7);
        exp_q.push_back(-7); exp_q.push_back(-7);
        start_frame(6, 6, 1'b1, 1'b0);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                feed((r == 1 && c == 1) ? -2 : -7);
        in_valid = 1'b0;
        wait_done("t4");
        chk("t4_count", out_cnt - o0, 4);

        // average pooling, or max when the feature is absent
`ifdef AVG_POOL_EN
        exp_q.push_back(2); exp_q.push_back(4);
        exp_q.push_back(10); exp_q.push_back(12);
`else
        exp_q.push_back(5); exp_q.push_back(7);
        exp_q.push_back(13); exp_q.push_back(15);
`endif
        ramp(4, 4, 1'b0, 1'b1);
        wait_done("t5a");
        exp_q.push_back(100);
        start_frame(3, 3, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) feed(100);
        in_valid = 1'b0;
        wait_done("t5b");

        // zero-size frame: done with no outputs
        o0 = out_cnt;
        start_frame(0, 4, 1'b0, 1'b0);
        wait_done("tz");
        chk("tz_count", out_cnt - o0, 0);

        // reset after 6 pixels, pixel 5 completes the first window
        exp_q.push_back(5);
        start_frame(4, 4, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) feed(i);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        o0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("t6_in_ready", int'(in_ready), 0);
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_out_data", int'(out_data), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_sb_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - o0, 0);
        o0 = out_cnt;
        exp_q.push_back(5); exp_q.push_back(7);
        exp_q.push_back(13); exp_q.push_back(15);
        ramp(4, 4, 1'b0, 1'b0);
        wait_done("t6r");
        chk("t6r_count", out_cnt - o0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
